// File: rtl/seg_scan_reader.sv
// Display-bus monitor: samples the multiplexed 7-segment lines, debounces each
// digit dwell, and publishes one decoded 4-digit frame per complete scan.
module seg_scan_reader #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  C,
    input  logic [3:0]  A,
    output logic [15:0] digits,
    output logic [6:0]  val_hi,
    output logic [6:0]  val_lo,
    output logic        frame_vld,
    output logic        frame_chg,
    output logic        seg_err,
    output logic        stale
);
    localparam int             NUM_DIG = 4;
    localparam logic [7:0]     STAB    = 8'(STABLE_CYC);
    localparam logic [15:0]    TMO     = 16'(TIMEOUT_CYC);
    localparam logic [15:0]    TMO_M1  = 16'(TIMEOUT_CYC - 1);

    function automatic logic [3:0] seg_dec(input logic [6:0] s);
        case (s)
            7'h01:   seg_dec = 4'd0;
            7'h4F:   seg_dec = 4'd1;
            7'h12:   seg_dec = 4'd2;
            7'h06:   seg_dec = 4'd3;
            7'h4C:   seg_dec = 4'd4;
            7'h24:   seg_dec = 4'd5;
            7'h20:   seg_dec = 4'd6;
            7'h0F:   seg_dec = 4'd7;
            7'h00:   seg_dec = 4'd8;
            7'h04:   seg_dec = 4'd9;
            7'h7F:   seg_dec = 4'hF;
            default: seg_dec = 4'hE;
        endcase
    endfunction

    // Blank reads as zero in the binary pair value.
    function automatic logic [6:0] pair_val(input logic [3:0] hi, input logic [3:0] lo);
        logic [6:0] h, l;
        h = (hi == 4'hF) ? 7'd0 : {3'b000, hi};
        l = (lo == 4'hF) ? 7'd0 : {3'b000, lo};
        pair_val = h * 7'd10 + l;
    endfunction

    logic [10:0]              ca_q;
    logic [7:0]               stab_cnt;
    logic                     held;
    logic [NUM_DIG-1:0]       seen;
    logic [NUM_DIG-1:0][3:0]  shadow;
    logic [15:0]              tcnt;

    logic [10:0]        ca_in;
    logic               sel_ok, diff, accept, publish, err_c;
    logic [NUM_DIG-1:0] acc_mask;
    logic [3:0]         acc_nib;

    assign ca_in    = {C, A};
    assign sel_ok   = ($countones(~A) == 1);
    assign diff     = (ca_in != ca_q);
    // stab_cnt only reaches STAB for a valid one-hot sample, so ca_q[3:0] is a clean select here
    assign accept   = (stab_cnt == STAB) && !held;
    assign acc_mask = ~ca_q[3:0] & {NUM_DIG{accept}};
    assign acc_nib  = seg_dec(ca_q[10:4]);
    assign publish  = &seen;

    always_comb begin
        err_c = 1'b0;
        for (int i = 0; i < NUM_DIG; i++)
            if (shadow[i] == 4'hE) err_c = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ca_q     <= '1;
            stab_cnt <= '0;
            held     <= 1'b0;
        end else begin
            ca_q <= ca_in;
            if (!sel_ok)
                stab_cnt <= '0;
            else if (diff)
                stab_cnt <= 8'd1;
            else if (stab_cnt != STAB)
                stab_cnt <= stab_cnt + 8'd1;
            held <= (diff || !sel_ok) ? 1'b0 : (held | accept);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIG; g++) begin : g_dig
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    shadow[g] <= 4'hF;
                else if (acc_mask[g])
                    shadow[g] <= acc_nib;
            end
        end
    endgenerate

    // An accept on the publish edge lands in the freshly cleared mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen      <= '0;
            digits    <= 16'hFFFF;
            val_hi    <= '0;
            val_lo    <= '0;
            frame_vld <= 1'b0;
            frame_chg <= 1'b0;
            seg_err   <= 1'b0;
        end else begin
            seen      <= (publish ? '0 : seen) | acc_mask;
            frame_vld <= publish;
            frame_chg <= 1'b0;
            if (publish) begin
                digits    <= shadow;
                frame_chg <= (shadow != digits);
                seg_err   <= err_c;
                val_hi    <= err_c ? 7'd0 : pair_val(shadow[3], shadow[2]);
                val_lo    <= err_c ? 7'd0 : pair_val(shadow[1], shadow[0]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else begin
            if (accept)
                tcnt <= '0;
            else if (tcnt != TMO)
                tcnt <= tcnt + 16'd1;
            stale <= !accept && (tcnt >= TMO_M1);
        end
    end
endmodule
